// File: rtl/route_request_initiator.sv
// route_request_initiator
//
// Per-input-port initiator for the switch-control reservation protocol. It
// sits between the input flit buffer and the crossbar. For every packet it
// decodes the route field of the head flit, requests that output port, waits
// for the one-cycle grant pulse, streams flits while the switch holds the
// path, and after the tail flit pulses routeRelieve to free the output.
//
// Flit types (top two bits of a flit):
//   2'b01 HEAD, 2'b00 BODY, 2'b10 TAIL, 2'b11 HEAD_TAIL (single-flit packet)
//
// Ports:
//   clk                      clock
//   rst                      asynchronous reset, active low
//   in_flit / in_valid       flit from the input buffer
//   in_ready                 flit consumed when in_valid & in_ready
//   out_flit / out_valid     flit towards the crossbar input
//   out_ready                downstream can accept
//   routeReserveRequestValid reservation request active
//   routeReserveRequest      requested output port
//   routeReserveStatus       one-cycle grant pulse from switch control
//   PortReserved             path currently held by switch control
//   routeRelieve             one-cycle path release
//   protocol_error           sticky framing-error flag
//
// Optional build macro ROUTE_STATS_EN adds two saturating statistics outputs:
//   pkt_count   [15:0]  packets relieved
//   wait_cycles [15:0]  cycles spent waiting for a grant
module route_request_initiator #(
  parameter int DATA_WIDTH    = 8,
  parameter int REQUEST_WIDTH = 2,
  parameter int MAX_FLITS     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_WIDTH-1:0]    in_flit,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [DATA_WIDTH-1:0]    out_flit,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     routeReserveRequestValid,
  output logic [REQUEST_WIDTH-1:0] routeReserveRequest,
  input  logic                     routeReserveStatus,
  input  logic                     PortReserved,
  output logic                     routeRelieve,
  output logic                     protocol_error
`ifdef ROUTE_STATS_EN
  ,
  output logic [15:0]              pkt_count,
  output logic [15:0]              wait_cycles
`endif
);

  localparam int CountWidth = $clog2(MAX_FLITS + 1);
  localparam logic [CountWidth-1:0] MaxCount = CountWidth'(MAX_FLITS);
  localparam logic [1:0] TypeHead = 2'b01;

  typedef enum logic [1:0] {
    Idle,
    WaitGrant,
    Stream,
    Relieve
  } stateType;

  stateType                 state, stateNext;
  logic [REQUEST_WIDTH-1:0] routeQ, routeNext;
  logic [CountWidth-1:0]    flitCount, flitCountNext;
  logic                     errorQ, errorNext;
  logic [1:0]               flitType;
  logic                     transfer;

  // Type encoding: bit 0 set means the flit opens a packet (HEAD, HEAD_TAIL),
  // bit 1 set means it closes one (TAIL, HEAD_TAIL).
  assign flitType       = in_flit[DATA_WIDTH-1 -: 2];
  assign protocol_error = errorQ;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= Idle;
      routeQ    <= '0;
      flitCount <= '0;
      errorQ    <= 1'b0;
    end else begin
      state     <= stateNext;
      routeQ    <= routeNext;
      flitCount <= flitCountNext;
      errorQ    <= errorNext;
    end
  end

  always_comb begin
    stateNext                = state;
    routeNext                = routeQ;
    flitCountNext            = flitCount;
    errorNext                = errorQ;
    in_ready                 = 1'b0;
    out_flit                 = '0;
    out_valid                = 1'b0;
    routeReserveRequestValid = 1'b0;
    routeReserveRequest      = '0;
    routeRelieve             = 1'b0;
    transfer                 = 1'b0;

    case (state)
      Idle: begin
        if (in_valid) begin
          if (flitType[0]) begin
            // Head stays in the buffer; it is forwarded once the path is held.
            routeNext = in_flit[REQUEST_WIDTH-1:0];
            stateNext = WaitGrant;
          end else begin
            // Orphan body/tail: drain it so the buffer cannot lock up. Gated
            // by rst so every output reads 0 while reset is held.
            in_ready  = rst;
            errorNext = 1'b1;
          end
        end
      end

      WaitGrant: begin
        routeReserveRequestValid = 1'b1;
        routeReserveRequest      = routeQ;
        if (routeReserveStatus) begin
          stateNext = Stream;
        end
      end

      Stream: begin
        routeReserveRequestValid = 1'b1;
        routeReserveRequest      = routeQ;
        out_flit                 = in_flit;
        out_valid                = in_valid & PortReserved;
        in_ready                 = out_ready & PortReserved;
        transfer                 = in_valid & in_ready;
        if (transfer) begin
          flitCountNext = flitCount + CountWidth'(1);
          // flitCount is zero only for the packet's own head flit.
          if (flitType == TypeHead && flitCount != '0) begin
            errorNext = 1'b1;
          end
          if (flitType[1]) begin
            stateNext = Relieve;
          end else if (flitCountNext == MaxCount) begin
            // Oversized packet: cut it here and release the output.
            errorNext = 1'b1;
            stateNext = Relieve;
          end
        end
      end

      Relieve: begin
        routeRelieve  = 1'b1;
        flitCountNext = '0;
        stateNext     = Idle;
      end

      default: begin
        stateNext = Idle;
      end
    endcase
  end

`ifdef ROUTE_STATS_EN
  logic [15:0] pktCountQ;
  logic [15:0] waitCyclesQ;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pktCountQ   <= '0;
      waitCyclesQ <= '0;
    end else begin
      if (stateNext == Relieve && state != Relieve && pktCountQ != 16'hFFFF) begin
        pktCountQ <= pktCountQ + 16'd1;
      end
      if (state == WaitGrant && waitCyclesQ != 16'hFFFF) begin
        waitCyclesQ <= waitCyclesQ + 16'd1;
      end
    end
  end

  assign pkt_count   = pktCountQ;
  assign wait_cycles = waitCyclesQ;
`endif

endmodule

// File: tb/tb_route_request_initiator.sv
// Testbench for route_request_initiator (MAX_FLITS overridden to 4 so the
// truncation rule is reachable). Each scenario is a list of input flits; a
// packet-level model derives the expected output flit stream, the routes
// requested, the number of relieves and the protocol_error flag from it.
module tb_route_request_initiator;

  localparam int DW   = 8;
  localparam int RW   = 2;
  localparam int MAXF = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] in_flit;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out_flit;
  logic          out_valid;
  logic          out_ready;
  logic          reqValid;
  logic [RW-1:0] reqRoute;
  logic          grant;
  logic          portReserved;
  logic          routeRelieve;
  logic          protocol_error;
`ifdef ROUTE_STATS_EN
  logic [15:0]   pkt_count;
  logic [15:0]   wait_cycles;
`endif

  route_request_initiator #(
    .DATA_WIDTH   (DW),
    .REQUEST_WIDTH(RW),
    .MAX_FLITS    (MAXF)
  ) dut (
    .clk                     (clk),
    .rst                     (rst),
    .in_flit                 (in_flit),
    .in_valid                (in_valid),
    .in_ready                (in_ready),
    .out_flit                (out_flit),
    .out_valid               (out_valid),
    .out_ready               (out_ready),
    .routeReserveRequestValid(reqValid),
    .routeReserveRequest     (reqRoute),
    .routeReserveStatus      (grant),
    .PortReserved            (portReserved),
    .routeRelieve            (routeRelieve),
    .protocol_error          (protocol_error)
`ifdef ROUTE_STATS_EN
    ,
    .pkt_count               (pkt_count),
    .wait_cycles             (wait_cycles)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model state
  logic [7:0] stim[$];
  logic [7:0] inQ[$];
  logic [7:0] expQ[$];
  logic [1:0] expRoutes[$];
  int         expPackets;
  logic       expErr;

  // Driver / monitor state
  bit         rnd;
  int         gDelay;
  int         reqAge;
  bit         granted;
  logic       prevReqValid;
  logic [1:0] curRoute;
  int         orAt, orLeft, prAt, prLeft;
  int         outXfers;
  int         relieves;
  int         idleRun;

  function automatic bit isHead(input logic [7:0] f);
    return (f[7:6] == 2'b01) || (f[7:6] == 2'b11);
  endfunction

  function automatic bit isTail(input logic [7:0] f);
    return (f[7:6] == 2'b10) || (f[7:6] == 2'b11);
  endfunction

  // Walk the flit list at packet level: orphan non-heads are dropped with an
  // error; a packet forwards flits up to its tail or until MAXF flits.
  task automatic loadStim();
    int i;
    int cnt;
    bit done;
    logic [7:0] f;
    i = 0;
    while (i < stim.size()) begin
      f = stim[i];
      if (!isHead(f)) begin
        expErr = 1'b1;
        i++;
      end else begin
        expRoutes.push_back(f[1:0]);
        expPackets++;
        cnt  = 0;
        done = 1'b0;
        while (!done && i < stim.size()) begin
          f = stim[i];
          expQ.push_back(f);
          cnt++;
          i++;
          if (isTail(f)) begin
            done = 1'b1;
          end else begin
            if (f[7:6] == 2'b01 && cnt > 1) expErr = 1'b1;
            if (cnt == MAXF) begin
              expErr = 1'b1;
              done   = 1'b1;
            end
          end
        end
      end
    end
    foreach (stim[k]) inQ.push_back(stim[k]);
    stim.delete();
  endtask

  // One clock cycle: check at the falling edge, update inputs 1 time unit
  // after the rising edge.
  task automatic step();
    logic consumed;
    @(negedge clk);
    if (out_valid && out_ready) begin
      if (expQ.size() == 0) check("out_unexpected", 32'(expQ.size()), 32'd1);
      else check("out_flit", 32'(out_flit), 32'(expQ.pop_front()));
      outXfers++;
    end
    consumed = in_valid && in_ready;
    if (routeRelieve) begin
      relieves++;
      check("relieve_req_low", 32'(reqValid), 32'd0);
    end
    if (reqValid && !prevReqValid) begin
      if (expRoutes.size() == 0) check("req_unexpected", 32'(expRoutes.size()), 32'd1);
      else check("req_route", 32'(reqRoute), 32'(expRoutes.pop_front()));
      curRoute = reqRoute;
    end else if (reqValid) begin
      check("req_stable", 32'(reqRoute), 32'(curRoute));
    end
    if (reqValid && !portReserved) check("stall_blocks", 32'({out_valid, in_ready}), 32'd0);
    if (!reqValid) check("no_out_unreserved", 32'(out_valid), 32'd0);
    idleRun      = (reqValid || routeRelieve) ? 0 : idleRun + 1;
    prevReqValid = reqValid;
    if (reqValid) reqAge++;
    else begin
      reqAge  = 0;
      granted = 1'b0;
    end

    @(posedge clk);
    #1;
    if (consumed) void'(inQ.pop_front());
    in_valid = (inQ.size() > 0) && (!rnd || ($urandom % 5 != 0));
    in_flit  = (inQ.size() > 0) ? inQ[0] : 8'($urandom);
    if (orLeft > 0 && outXfers == orAt) begin
      out_ready = 1'b0;
      orLeft--;
    end else begin
      out_ready = !rnd || ($urandom % 4 != 0);
    end
    if (prLeft > 0 && outXfers == prAt) begin
      portReserved = 1'b0;
      prLeft--;
    end else begin
      portReserved = !rnd || ($urandom % 4 != 0);
    end
    if (prevReqValid && !granted && reqAge >= gDelay) begin
      grant   = 1'b1;
      granted = 1'b1;
      gDelay  = rnd ? int'($urandom_range(1, 4)) : 2;
    end else begin
      // Stray grants only where the DUT cannot be waiting for one.
      grant = rnd && ((prevReqValid && granted) || routeRelieve) && ($urandom % 4 == 0);
    end
  endtask

  task automatic runScenario(input string tag, input int budget);
    int cyc;
    expPackets = 0;
    relieves   = 0;
    outXfers   = 0;
    idleRun    = 0;
    loadStim();
    cyc = 0;
    while (cyc < budget && !(inQ.size() == 0 && expQ.size() == 0 && idleRun >= 3)) begin
      step();
      cyc++;
    end
    check($sformatf("%s.in_budget", tag), 32'(cyc < budget), 32'd1);
    check($sformatf("%s.relieves", tag), 32'(relieves), 32'(expPackets));
    check($sformatf("%s.protocol_error", tag), 32'(protocol_error), 32'(expErr));
    check($sformatf("%s.drained", tag), 32'(expQ.size()), 32'd0);
    orLeft = 0;
    prLeft = 0;
  endtask

  initial begin
    int np;
    int r;
    int nb;
    rst          = 1'b0;
    in_flit      = 8'h05;
    in_valid     = 1'b1;
    out_ready    = 1'b1;
    grant        = 1'b0;
    portReserved = 1'b1;
    rnd          = 1'b0;
    gDelay       = 2;
    reqAge       = 0;
    granted      = 1'b0;
    prevReqValid = 1'b0;
    curRoute     = '0;
    orAt = 0; orLeft = 0; prAt = 0; prLeft = 0;
    expErr       = 1'b0;
    expPackets   = 0;

    // Reset state, with an orphan body flit presented at the input
    #12;
    check("reset_outputs",
          32'({in_ready, out_flit, out_valid, reqValid, reqRoute, routeRelieve, protocol_error}),
          32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // Single HEAD_TAIL flit, grant two cycles after the request
    stim = '{8'hC2};
    runScenario("head_tail", 60);

    // Four-flit packet with out_ready held low for 3 cycles mid-packet
    stim = '{8'h41, 8'h01, 8'h02, 8'h83};
    orAt = 2; orLeft = 3;
    runScenario("out_stall", 80);

    // PortReserved dropped for 2 cycles during streaming
    stim = '{8'h42, 8'h11, 8'h12, 8'h93};
    prAt = 1; prLeft = 2;
    runScenario("port_stall", 80);

    // Orphan BODY in IDLE
    stim = '{8'h05};
    runScenario("orphan_body", 40);

    // Truncation: HEAD followed by 6 BODY flits with MAX_FLITS = 4
    stim = '{8'h40, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    runScenario("truncate", 100);

    // Randomized traffic, handshakes and grant latency
    rnd    = 1'b1;
    gDelay = 1;
    for (int s = 0; s < 10; s++) begin
      np = int'($urandom_range(1, 4));
      for (int p = 0; p < np; p++) begin
        r = int'($urandom % 8);
        if (r == 0) begin
          stim.push_back({2'b00, 6'($urandom)});
        end else if (r == 1) begin
          stim.push_back({2'b11, 6'($urandom)});
        end else begin
          stim.push_back({2'b01, 6'($urandom)});
          nb = int'($urandom % 6);
          for (int b = 0; b < nb; b++) stim.push_back({2'b00, 6'($urandom)});
          stim.push_back({2'b10, 6'($urandom)});
        end
      end
      runScenario($sformatf("random%0d", s), 600);
    end

    // Asynchronous reset while streaming
    rnd    = 1'b0;
    gDelay = 2;
    stim   = '{8'h44, 8'h0A, 8'h0B, 8'h8C};
    expPackets = 0;
    relieves   = 0;
    outXfers   = 0;
    loadStim();
    for (int k = 0; k < 50 && outXfers < 1; k++) step();
    check("reached_stream", 32'(outXfers >= 1), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("async_reset_outputs",
          32'({in_ready, out_flit, out_valid, reqValid, reqRoute, routeRelieve, protocol_error}),
          32'd0);
    inQ.delete();
    expQ.delete();
    expRoutes.delete();
    expErr       = 1'b0;
    in_valid     = 1'b0;
    grant        = 1'b0;
    prevReqValid = 1'b0;
    reqAge       = 0;
    granted      = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // Fresh packet after reset must request port 3
    stim = '{8'h43, 8'h80};
    runScenario("after_reset", 60);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
